// File: rtl/gradient_adder_sched.sv
// Round-robin scheduler sharing one registered signed gradient adder among NUM_REQ requesters.
// Issues at most one grant per cycle and returns id-tagged sums with a signed-overflow flag.
module gradient_adder_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      halt,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  output logic                      add_en,
  input  logic [DATA_W-1:0]         add_sum,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_ovf,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   off_sel;
  logic [ID_W:0]     id_sum;
  logic [ID_W-1:0]   gnt_id;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic              any_req;
  logic              grant_ok;
  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  logic              s1_sa;
  logic              s1_sb;

  assign any_req  = |req;
  // Grants are gated by reset so every output reads 0 while resetb is low.
  assign grant_ok = resetb && !halt && any_req && (state != DRAIN);
  assign busy     = (state != IDLE);

  // Rotate requests so the pointer position becomes bit 0, then take the lowest set bit.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    off_sel = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_rot[off]) off_sel = ID_W'(off);
    end
  end

  assign id_sum = {1'b0, ptr} + {1'b0, off_sel};
  assign gnt_id = (id_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(id_sum - (ID_W+1)'(NUM_REQ))
                                                 : ID_W'(id_sum);

  always_comb begin
    gnt   = '0;
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = grant_ok && (gnt_id == ID_W'(i));
      if (gnt[i]) begin
        add_a = req_a[i*DATA_W +: DATA_W];
        add_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign add_en = |gnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req && !halt) state_nxt = ACTIVE;
      ACTIVE: begin
        if (halt)          state_nxt = DRAIN;
        else if (!any_req) state_nxt = s1_valid ? DRAIN : IDLE;
      end
      DRAIN:   if (!s1_valid) state_nxt = (any_req && !halt) ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (add_en) ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Stage 1 travels alongside the adder's own register; the response stage follows it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_sa     <= 1'b0;
      s1_sb     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      s1_valid  <= add_en;
      s1_id     <= gnt_id;
      s1_sa     <= add_a[DATA_W-1];
      s1_sb     <= add_b[DATA_W-1];
      rsp_valid <= s1_valid;
      rsp_id    <= s1_valid ? s1_id : '0;
      rsp_sum   <= s1_valid ? add_sum : '0;
      rsp_ovf   <= s1_valid && (s1_sa == s1_sb) && (add_sum[DATA_W-1] != s1_sa);
    end
  end

endmodule
